// File: rtl/cla16_result_checker.sv
// Result checker for the 16-bit CLA: recomputes each sum, counts vectors and mismatches
// over a fixed-length run, and captures the first failing vector.
module cla16_result_checker #(
   parameter int WIDTH       = 16,
   parameter int NUM_VECTORS = 10,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_ci,
   input  logic [WIDTH-1:0] dut_s,
   input  logic             dut_co,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] err_count,
   output logic             fail_valid,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic [WIDTH:0]   fail_got,
   output logic [WIDTH:0]   fail_exp
);

   localparam int ACC_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
   localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(NUM_VECTORS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Golden result keeps the carry as bit WIDTH.
   function automatic logic [WIDTH:0] golden_sum(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic             ci);
      return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
   endfunction

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;

   logic             vld_p1_q, vld_p1_d;
   logic [WIDTH-1:0] a_p1_q, a_p1_d;
   logic [WIDTH-1:0] b_p1_q, b_p1_d;
   logic [WIDTH:0]   got_p1_q, got_p1_d;
   logic [WIDTH:0]   exp_p1_q, exp_p1_d;

   logic             vld_p2_q, vld_p2_d;
   logic             mis_p2_q, mis_p2_d;
   logic [WIDTH-1:0] a_p2_q, a_p2_d;
   logic [WIDTH-1:0] b_p2_q, b_p2_d;
   logic [WIDTH:0]   got_p2_q, got_p2_d;
   logic [WIDTH:0]   exp_p2_q, exp_p2_d;

   logic [CNT_W-1:0] vec_q, vec_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic             fail_valid_q, fail_valid_d;
   logic [WIDTH-1:0] fail_a_q, fail_a_d;
   logic [WIDTH-1:0] fail_b_q, fail_b_d;
   logic [WIDTH:0]   fail_got_q, fail_got_d;
   logic [WIDTH:0]   fail_exp_q, fail_exp_d;

   logic accept;
   logic start_ok;

   assign accept   = in_valid && (state_q == RUN);
   assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      case (state_q)
         IDLE:  if (start) state_d = RUN;
         RUN:   if (accept && (acc_q == ACC_LAST)) state_d = DRAIN;
         // S1 empty now means S2 empties on this edge as well.
         DRAIN: if (!vld_p1_q) state_d = DONE;
         DONE:  if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
      if (start_ok) begin
         acc_d = '0;
      end else if (accept) begin
         acc_d = (acc_q == ACC_LAST) ? '0 : acc_q + 1'b1;
      end
   end

   always_comb begin
      in_ready = (state_q == RUN);
      busy     = (state_q == RUN) || (state_q == DRAIN);
      done     = (state_q == DONE);
      pass     = (state_q == DONE) && (err_q == '0);
   end

   always_comb begin
      // S1: register the beat and its golden result
      vld_p1_d = accept;
      a_p1_d   = a_p1_q;
      b_p1_d   = b_p1_q;
      got_p1_d = got_p1_q;
      exp_p1_d = exp_p1_q;
      if (accept) begin
         a_p1_d   = in_a;
         b_p1_d   = in_b;
         got_p1_d = {dut_co, dut_s};
         exp_p1_d = golden_sum(in_a, in_b, in_ci);
      end

      // S2: compare
      vld_p2_d = vld_p1_q;
      mis_p2_d = vld_p1_q && (got_p1_q != exp_p1_q);
      a_p2_d   = a_p1_q;
      b_p2_d   = b_p1_q;
      got_p2_d = got_p1_q;
      exp_p2_d = exp_p1_q;

      // Result registers: counters and first-fail capture
      vec_d        = vec_q;
      err_d        = err_q;
      fail_valid_d = fail_valid_q;
      fail_a_d     = fail_a_q;
      fail_b_d     = fail_b_q;
      fail_got_d   = fail_got_q;
      fail_exp_d   = fail_exp_q;
      if (start_ok) begin
         vec_d        = '0;
         err_d        = '0;
         fail_valid_d = 1'b0;
         fail_a_d     = '0;
         fail_b_d     = '0;
         fail_got_d   = '0;
         fail_exp_d   = '0;
      end else if (vld_p2_q) begin
         vec_d = sat_inc(vec_q);
         if (mis_p2_q) begin
            err_d = sat_inc(err_q);
            if (!fail_valid_q) begin
               fail_valid_d = 1'b1;
               fail_a_d     = a_p2_q;
               fail_b_d     = b_p2_q;
               fail_got_d   = got_p2_q;
               fail_exp_d   = exp_p2_q;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_q     <= 1'b0;
         a_p1_q       <= '0;
         b_p1_q       <= '0;
         got_p1_q     <= '0;
         exp_p1_q     <= '0;
         vld_p2_q     <= 1'b0;
         mis_p2_q     <= 1'b0;
         a_p2_q       <= '0;
         b_p2_q       <= '0;
         got_p2_q     <= '0;
         exp_p2_q     <= '0;
         vec_q        <= '0;
         err_q        <= '0;
         fail_valid_q <= 1'b0;
         fail_a_q     <= '0;
         fail_b_q     <= '0;
         fail_got_q   <= '0;
         fail_exp_q   <= '0;
      end else begin
         vld_p1_q     <= vld_p1_d;
         a_p1_q       <= a_p1_d;
         b_p1_q       <= b_p1_d;
         got_p1_q     <= got_p1_d;
         exp_p1_q     <= exp_p1_d;
         vld_p2_q     <= vld_p2_d;
         mis_p2_q     <= mis_p2_d;
         a_p2_q       <= a_p2_d;
         b_p2_q       <= b_p2_d;
         got_p2_q     <= got_p2_d;
         exp_p2_q     <= exp_p2_d;
         vec_q        <= vec_d;
         err_q        <= err_d;
         fail_valid_q <= fail_valid_d;
         fail_a_q     <= fail_a_d;
         fail_b_q     <= fail_b_d;
         fail_got_q   <= fail_got_d;
         fail_exp_q   <= fail_exp_d;
      end
   end

   assign vec_count  = vec_q;
   assign err_count  = err_q;
   assign fail_valid = fail_valid_q;
   assign fail_a     = fail_a_q;
   assign fail_b     = fail_b_q;
   assign fail_got   = fail_got_q;
   assign fail_exp   = fail_exp_q;

endmodule

// File: tb/tb_cla16_result_checker.sv
// Directed bench for cla16_result_checker: table-driven run plus multi-cycle corner sequences.
module tb_cla16_result_checker;

   localparam int W  = 16;
   localparam int NV = 10;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          in_ci = 1'b0;
   logic [W-1:0]  dut_s = '0;
   logic          dut_co = 1'b0;
   logic          in_ready, busy, done, pass, fail_valid;
   logic [CW-1:0] vec_count, err_count;
   logic [W-1:0]  fail_a, fail_b;
   logic [W:0]    fail_got, fail_exp;

   cla16_result_checker #(.WIDTH(W), .NUM_VECTORS(NV), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .dut_s(dut_s), .dut_co(dut_co),
      .busy(busy), .done(done), .pass(pass), .vec_count(vec_count), .err_count(err_count),
      .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b),
      .fail_got(fail_got), .fail_exp(fail_exp)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        ci;
      logic [15:0] s;
      logic        co;
      logic        bad;
   } vec_t;

   vec_t tbl [NV];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic [15:0] s, input logic co);
      in_a = a; in_b = b; in_ci = ci; dut_s = s; dut_co = co;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_good(input int n);
      for (int k = 0; k < n; k++) beat(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
   endtask

   // Called one cycle-offset after the last accepted beat.
   task automatic expect_done(input string tag, input int ev, input int ee);
      chk({tag, "_rdy_drain"}, 32'(in_ready), 0);
      chk({tag, "_busy_drain"}, 32'(busy), 1);
      tick();
      chk({tag, "_done_early"}, 32'(done), 0);
      tick();
      chk({tag, "_done"}, 32'(done), 1);
      chk({tag, "_busy_done"}, 32'(busy), 0);
      chk({tag, "_vec"}, 32'(vec_count), 32'(ev));
      chk({tag, "_err"}, 32'(err_count), 32'(ee));
      chk({tag, "_pass"}, 32'(pass), (ee == 0) ? 1 : 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_pass"}, 32'(pass), 0);
      chk({tag, "_rdy"}, 32'(in_ready), 0);
      chk({tag, "_vec"}, 32'(vec_count), 0);
      chk({tag, "_err"}, 32'(err_count), 0);
      chk({tag, "_fv"}, 32'(fail_valid), 0);
      chk({tag, "_fa"}, 32'(fail_a), 0);
      chk({tag, "_fgot"}, 32'(fail_got), 0);
      chk({tag, "_fexp"}, 32'(fail_exp), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_err;
      int offered;
      int cyc;

      //                a         b       ci    s         co    bad
      tbl[0] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
      tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[2] = '{16'h1234, 16'h1111, 1'b0, 16'h2346, 1'b0, 1'b1};
      tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
      tbl[6] = '{16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b1, 1'b1};
      tbl[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0};
      tbl[8] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0};
      tbl[9] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};

      // Reset state
      tick();
      tick();
      chk_all_zero("rst");
      rst_n = 1'b1;
      tick();
      chk_all_zero("idle");

      // Clean 10-vector run
      do_start();
      chk("t1_busy", 32'(busy), 1);
      chk("t1_rdy", 32'(in_ready), 1);
      send_good(NV);
      expect_done("t1", 10, 0);
      chk("t1_fv", 32'(fail_valid), 0);

      // Table run: carry-out cases, two mismatches, per-beat latency
      do_start();
      chk("t3_vec_clr", 32'(vec_count), 0);
      chk("t3_done_clr", 32'(done), 0);
      for (int i = 0; i < NV; i++) begin
         in_a = tbl[i].a; in_b = tbl[i].b; in_ci = tbl[i].ci;
         dut_s = tbl[i].s; dut_co = tbl[i].co;
         in_valid = 1'b1;
         chk("t3_rdy", 32'(in_ready), 1);
         tick();
         exp_err = 0;
         for (int j = 0; j <= i - 2; j++) exp_err += int'(tbl[j].bad);
         chk("t3_vec_lat", 32'(vec_count), (i >= 1) ? 32'(i - 1) : 0);
         chk("t3_err_lat", 32'(err_count), 32'(exp_err));
      end
      in_valid = 1'b0;
      exp_err = 0;
      for (int j = 0; j < NV; j++) exp_err += int'(tbl[j].bad);
      expect_done("t3", 10, exp_err);
      chk("t3_fv", 32'(fail_valid), 1);
      chk("t3_fa", 32'(fail_a), 32'h1234);
      chk("t3_fb", 32'(fail_b), 32'h1111);
      chk("t3_fgot", 32'(fail_got), 32'h02346);
      chk("t3_fexp", 32'(fail_exp), 32'h02345);

      // Gapped input, then extra (bad) beats offered during DRAIN/DONE
      do_start();
      chk("t4_err_clr", 32'(err_count), 0);
      chk("t4_fv_clr", 32'(fail_valid), 0);
      chk("t4_fa_clr", 32'(fail_a), 0);
      offered = 0;
      cyc = 0;
      in_a = 16'h0001; in_b = 16'h0002; in_ci = 1'b0; dut_s = 16'h0003; dut_co = 1'b0;
      while (offered < NV && cyc < 40) begin
         in_valid = (cyc % 2 == 0);
         if (in_valid) begin
            chk("t4_rdy", 32'(in_ready), 1);
            offered++;
         end
         tick();
         cyc++;
      end
      dut_s = 16'hFFFF;
      for (int k = 0; k < 8; k++) begin
         in_valid = (k % 2 == 1);
         chk("t4_rdy_after", 32'(in_ready), 0);
         tick();
      end
      in_valid = 1'b0;
      chk("t4_done", 32'(done), 1);
      chk("t4_vec", 32'(vec_count), 10);
      chk("t4_err", 32'(err_count), 0);
      chk("t4_pass", 32'(pass), 1);

      // Asynchronous reset mid-run, then a clean rerun
      do_start();
      beat(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
      beat(16'h1234, 16'h1111, 1'b0, 16'h2346, 1'b0);
      beat(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
      beat(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
      tick();
      tick();
      chk("t5_vec_pre", 32'(vec_count), 4);
      chk("t5_err_pre", 32'(err_count), 1);
      chk("t5_fv_pre", 32'(fail_valid), 1);
      chk("t5_busy_pre", 32'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("t5_async");
      tick();
      rst_n = 1'b1;
      tick();
      chk_all_zero("t5_idle");
      do_start();
      send_good(NV);
      expect_done("t5", 10, 0);

      // start ignored in RUN and DRAIN, honoured in DONE
      do_start();
      send_good(3);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t6_busy", 32'(busy), 1);
      chk("t6_vec_kept", 32'(vec_count), 2);
      beat(16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b0);
      send_good(6);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t6_done_drain", 32'(done), 0);
      chk("t6_busy_drain", 32'(busy), 1);
      tick();
      chk("t6_done", 32'(done), 1);
      chk("t6_vec", 32'(vec_count), 10);
      chk("t6_err", 32'(err_count), 1);
      chk("t6_pass", 32'(pass), 0);
      chk("t6_fa", 32'(fail_a), 32'h0F0F);
      chk("t6_fgot", 32'(fail_got), 32'h00000);
      chk("t6_fexp", 32'(fail_exp), 32'h10000);
      do_start();
      chk("t6_rs_vec", 32'(vec_count), 0);
      chk("t6_rs_err", 32'(err_count), 0);
      chk("t6_rs_fv", 32'(fail_valid), 0);
      chk("t6_rs_fexp", 32'(fail_exp), 0);
      chk("t6_rs_done", 32'(done), 0);
      chk("t6_rs_pass", 32'(pass), 0);
      chk("t6_rs_busy", 32'(busy), 1);
      send_good(NV);
      expect_done("t6r", 10, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
